// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port main-memory arbiter for the write buffer, dcache and icache.
// Fixed priority (wb > primary read > secondary read) with a write-run limit so a
// pending read cannot be starved, plus a watchdog that rescues a hung memory.
module mem_arbiter #(
  parameter int WBMAXRUN = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swc,
  input  logic [29:0] wbadr,
  input  logic [31:0] wbdata,
  input  logic [3:0]  wbbyteen,
  input  logic        wben,
  output logic        wbdone,
  input  logic [29:0] dadr,
  input  logic        den,
  output logic        ddone,
  input  logic [29:0] iadr,
  input  logic        ien,
  output logic        idone,
  output logic [31:0] rdata,
  output logic [29:0] memadr,
  output logic [31:0] memwdata,
  output logic [3:0]  membyteen,
  output logic        memrwb,
  output logic        memen,
  input  logic [31:0] memrdata,
  input  logic        memdone,
  output logic        memerr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_WB, OWN_D, OWN_I} owner_t;

  state_t      state, state_next;
  owner_t      owner, owner_next;
  logic [3:0]  runcnt, runcnt_next;
  logic [7:0]  waitcnt, waitcnt_next;

  logic [29:0] memadr_next;
  logic [31:0] memwdata_next;
  logic [3:0]  membyteen_next;
  logic        memrwb_next;
  logic        memen_next;
  logic [31:0] rdata_next;
  logic        memerr_next;
  logic        wbdone_next;
  logic        ddone_next;
  logic        idone_next;

  logic        read_pend;
  logic        wb_wins;
  owner_t      rd_owner;
  logic [29:0] rd_adr;

  // Request decode: which read would win, and whether the write buffer keeps the bus
  always_comb begin
    read_pend = den | ien;
    wb_wins   = wben && !(read_pend && (runcnt == 4'(WBMAXRUN)));
    if (swc) begin
      rd_owner = ien ? OWN_I : OWN_D;
    end else begin
      rd_owner = den ? OWN_D : OWN_I;
    end
    rd_adr = (rd_owner == OWN_I) ? iadr : dadr;
  end

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP transfer sequence
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    runcnt_next    = runcnt;
    waitcnt_next   = waitcnt;
    memadr_next    = memadr;
    memwdata_next  = memwdata;
    membyteen_next = membyteen;
    memrwb_next    = memrwb;
    memen_next     = memen;
    rdata_next     = rdata;
    memerr_next    = memerr;
    wbdone_next    = 1'b0;
    ddone_next     = 1'b0;
    idone_next     = 1'b0;

    case (state)
      IDLE: begin
        waitcnt_next = 8'd0;
        if (wb_wins) begin
          owner_next     = OWN_WB;
          memadr_next    = wbadr;
          memwdata_next  = wbdata;
          membyteen_next = wbbyteen;
          memrwb_next    = 1'b0;
          memen_next     = 1'b1;
          runcnt_next    = read_pend ? runcnt + 4'd1 : 4'd0;
          state_next     = ISSUE;
        end else if (read_pend) begin
          owner_next     = rd_owner;
          memadr_next    = rd_adr;
          membyteen_next = 4'b1111;
          memrwb_next    = 1'b1;
          memen_next     = 1'b1;
          runcnt_next    = 4'd0;
          state_next     = ISSUE;
        end else begin
          runcnt_next = 4'd0;
        end
      end

      ISSUE: begin
        state_next = WAIT;
      end

      WAIT: begin
        if (memdone) begin
          memen_next = 1'b0;
          if (owner != OWN_WB) begin
            rdata_next = memrdata;
          end
          wbdone_next = (owner == OWN_WB);
          ddone_next  = (owner == OWN_D);
          idone_next  = (owner == OWN_I);
          state_next  = RESP;
        end else if (waitcnt == 8'(TIMEOUT - 1)) begin
          memerr_next = 1'b1;
          memen_next  = 1'b0;
          if (owner != OWN_WB) begin
            rdata_next = 32'hDEADBEEF;
          end
          wbdone_next = (owner == OWN_WB);
          ddone_next  = (owner == OWN_D);
          idone_next  = (owner == OWN_I);
          state_next  = RESP;
        end else begin
          waitcnt_next = waitcnt + 8'd1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the bus immediately, even mid-transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_WB;
      runcnt    <= 4'd0;
      waitcnt   <= 8'd0;
      memadr    <= 30'd0;
      memwdata  <= 32'd0;
      membyteen <= 4'd0;
      memrwb    <= 1'b1;
      memen     <= 1'b0;
      rdata     <= 32'd0;
      memerr    <= 1'b0;
      wbdone    <= 1'b0;
      ddone     <= 1'b0;
      idone     <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      runcnt    <= runcnt_next;
      waitcnt   <= waitcnt_next;
      memadr    <= memadr_next;
      memwdata  <= memwdata_next;
      membyteen <= membyteen_next;
      memrwb    <= memrwb_next;
      memen     <= memen_next;
      rdata     <= rdata_next;
      memerr    <= memerr_next;
      wbdone    <= wbdone_next;
      ddone     <= ddone_next;
      idone     <= idone_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Requester and memory models run on the falling edge; expected completions are
// queued when requests are issued and popped whenever a done pulse appears.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swc = 1'b0;
  logic [29:0] wbadr = 30'd0;
  logic [31:0] wbdata = 32'd0;
  logic [3:0]  wbbyteen = 4'd0;
  logic        wben = 1'b0;
  logic        wbdone;
  logic [29:0] dadr = 30'd0;
  logic        den = 1'b0;
  logic        ddone;
  logic [29:0] iadr = 30'd0;
  logic        ien = 1'b0;
  logic        idone;
  logic [31:0] rdata;
  logic [29:0] memadr;
  logic [31:0] memwdata;
  logic [3:0]  membyteen;
  logic        memrwb;
  logic        memen;
  logic [31:0] memrdata = 32'd0;
  logic        memdone = 1'b0;
  logic        memerr;

  mem_arbiter #(.WBMAXRUN(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .swc(swc),
    .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen), .wben(wben), .wbdone(wbdone),
    .dadr(dadr), .den(den), .ddone(ddone),
    .iadr(iadr), .ien(ien), .idone(idone),
    .rdata(rdata),
    .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen), .memrwb(memrwb),
    .memen(memen), .memrdata(memrdata), .memdone(memdone), .memerr(memerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [29:0] adr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          memcyc;
  } exp_t;

  typedef struct {
    logic [29:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } wreq_t;

  exp_t        sb[$];
  wreq_t       wq[$];
  logic [29:0] dq[$];
  logic [29:0] iq[$];

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 2;
  logic        mem_stall = 1'b0;
  logic [31:0] last_rd = 32'd0;

  int          busy = 0;
  int          cyc = 0;
  logic        memen_q = 1'b0;
  logic [29:0] cap_adr = 30'd0;
  logic [31:0] cap_wd = 32'd0;
  logic [3:0]  cap_be = 4'd0;
  logic        cap_rwb = 1'b0;
  exp_t        e;

  function automatic logic [31:0] mem_model(input logic [29:0] a);
    if (a == 30'h4AD) return 32'h21212121;
    return {a, 2'b00} ^ 32'hA5A5_0000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Queue an expected completion; read data and bus occupancy follow the memory model settings
  task automatic push_exp(input int owner, input logic [29:0] adr, input logic [31:0] wd, input logic [3:0] be);
    exp_t x;
    x.owner = owner;
    x.adr   = adr;
    x.wdata = wd;
    if (owner == 0) begin
      x.be    = be;
      x.rdata = last_rd;
    end else begin
      x.be    = 4'b1111;
      x.rdata = mem_stall ? 32'hDEADBEEF : mem_model(adr);
      last_rd = x.rdata;
    end
    x.memcyc = mem_stall ? 9 : mem_lat + 1;
    sb.push_back(x);
  endtask

  task automatic apply_stimulus(input int owner, input logic [29:0] adr, input logic [31:0] wd, input logic [3:0] be);
    wreq_t w;
    if (owner == 0) begin
      w.adr = adr; w.data = wd; w.be = be;
      wq.push_back(w);
    end else if (owner == 1) begin
      dq.push_back(adr);
    end else begin
      iq.push_back(adr);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while ((sb.size() != 0 || wq.size() != 0 || dq.size() != 0 || iq.size() != 0) && k < max_cyc) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check_output("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_memen"},     {31'd0, memen},     32'd0);
    check_output({tag, "_memadr"},    {2'd0, memadr},     32'd0);
    check_output({tag, "_memwdata"},  memwdata,           32'd0);
    check_output({tag, "_membyteen"}, {28'd0, membyteen}, 32'd0);
    check_output({tag, "_memrwb"},    {31'd0, memrwb},    32'd1);
    check_output({tag, "_dones"},     {29'd0, idone, ddone, wbdone}, 32'd0);
    check_output({tag, "_rdata"},     rdata,              32'd0);
    check_output({tag, "_memerr"},    {31'd0, memerr},    32'd0);
  endtask

  // Memory model, transfer capture, scoreboard compare and requester updates
  always @(negedge clk) begin
    if (memen && !reset) begin
      busy++;
      memdone  = !mem_stall && (busy > mem_lat);
      memrdata = mem_model(memadr);
    end else begin
      busy    = 0;
      memdone = 1'b0;
    end

    if (memen && !memen_q) begin
      cap_adr = memadr; cap_wd = memwdata; cap_be = membyteen; cap_rwb = memrwb;
      cyc = 0;
    end
    if (memen) cyc++;
    memen_q = memen;

    if (wbdone || ddone || idone) begin
      if (sb.size() == 0) begin
        check_output("unexpected_done", {29'd0, idone, ddone, wbdone}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("done_owner", {29'd0, idone, ddone, wbdone}, 32'd1 << e.owner);
        check_output("memadr",     {2'd0, cap_adr},  {2'd0, e.adr});
        check_output("memrwb",     {31'd0, cap_rwb}, (e.owner == 0) ? 32'd0 : 32'd1);
        check_output("membyteen",  {28'd0, cap_be},  {28'd0, e.be});
        if (e.owner == 0) check_output("memwdata", cap_wd, e.wdata);
        check_output("rdata",        rdata,       e.rdata);
        check_output("memen_cycles", 32'(cyc),    32'(e.memcyc));
      end
    end

    if (wbdone && wq.size() > 0) void'(wq.pop_front());
    if (ddone && dq.size() > 0) void'(dq.pop_front());
    if (idone && iq.size() > 0) void'(iq.pop_front());
    wben = (wq.size() > 0);
    if (wben) begin
      wbadr = wq[0].adr; wbdata = wq[0].data; wbbyteen = wq[0].be;
    end
    den = (dq.size() > 0);
    if (den) dadr = dq[0];
    ien = (iq.size() > 0);
    if (ien) iadr = iq[0];
  end

  // Directed sequence
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    #2 reset = 1'b0;

    // Single dcache read, two-cycle memory
    @(posedge clk); #1;
    swc = 1'b0; mem_lat = 2;
    apply_stimulus(1, 30'h4AD, 32'd0, 4'd0);
    push_exp(1, 30'h4AD, 32'd0, 4'd0);
    wait_drain(50);

    // All three at once, dcache primary
    apply_stimulus(0, 30'h100, 32'hCAFE0001, 4'b0011);
    apply_stimulus(1, 30'h200, 32'd0, 4'd0);
    apply_stimulus(2, 30'h300, 32'd0, 4'd0);
    push_exp(0, 30'h100, 32'hCAFE0001, 4'b0011);
    push_exp(1, 30'h200, 32'd0, 4'd0);
    push_exp(2, 30'h300, 32'd0, 4'd0);
    wait_drain(100);

    // All three at once, icache primary
    swc = 1'b1; mem_lat = 3;
    apply_stimulus(0, 30'h110, 32'hCAFE0002, 4'b1100);
    apply_stimulus(1, 30'h210, 32'd0, 4'd0);
    apply_stimulus(2, 30'h310, 32'd0, 4'd0);
    push_exp(0, 30'h110, 32'hCAFE0002, 4'b1100);
    push_exp(2, 30'h310, 32'd0, 4'd0);
    push_exp(1, 30'h210, 32'd0, 4'd0);
    wait_drain(100);

    // Six queued writes against one dcache read: run limit lets the read in after four
    swc = 1'b0; mem_lat = 1;
    for (int k = 0; k < 6; k++) apply_stimulus(0, 30'h500 + 30'(k), 32'h1000_0000 + 32'(k), 4'b1111);
    apply_stimulus(1, 30'h600, 32'd0, 4'd0);
    for (int k = 0; k < 4; k++) push_exp(0, 30'h500 + 30'(k), 32'h1000_0000 + 32'(k), 4'b1111);
    push_exp(1, 30'h600, 32'd0, 4'd0);
    for (int k = 4; k < 6; k++) push_exp(0, 30'h500 + 30'(k), 32'h1000_0000 + 32'(k), 4'b1111);
    wait_drain(200);

    // Hung memory: watchdog fires, memerr sticks across a later good read
    check_output("memerr_before_timeout", {31'd0, memerr}, 32'd0);
    mem_stall = 1'b1;
    apply_stimulus(2, 30'h3C0, 32'd0, 4'd0);
    push_exp(2, 30'h3C0, 32'd0, 4'd0);
    wait_drain(100);
    check_output("memerr_after_timeout", {31'd0, memerr}, 32'd1);
    mem_stall = 1'b0; mem_lat = 2;
    apply_stimulus(1, 30'h055, 32'd0, 4'd0);
    push_exp(1, 30'h055, 32'd0, 4'd0);
    wait_drain(50);
    check_output("memerr_sticky", {31'd0, memerr}, 32'd1);

    // Reset asserted mid-transfer, then a clean read
    mem_stall = 1'b1;
    apply_stimulus(1, 30'h077, 32'd0, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    check_output("t6_memen_busy", {31'd0, memen}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset("midreset");
    sb.delete();
    dq.delete();
    last_rd = 32'd0;
    @(posedge clk); #2;
    reset = 1'b0;
    mem_stall = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(1, 30'h088, 32'd0, 4'd0);
    push_exp(1, 30'h088, 32'd0, 4'd0);
    wait_drain(50);
    check_output("memerr_cleared", {31'd0, memerr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
